// File: rtl/input_event_unit_pkg.sv
// Shared definitions for the input event front end: event codes and the
// priority pick used when several events qualify in the same cycle.
package input_event_unit_pkg;

    localparam int EV_W = 5;
    localparam int N_EV = 7;

    typedef logic [EV_W-1:0] ev_code_t;

    localparam ev_code_t EV_NONE   = 5'd0;
    localparam ev_code_t EV_UP     = 5'd1;
    localparam ev_code_t EV_DOWN   = 5'd2;
    localparam ev_code_t EV_LEFT   = 5'd3;
    localparam ev_code_t EV_RIGHT  = 5'd4;
    localparam ev_code_t EV_CENTER = 5'd5;
    localparam ev_code_t EV_CW     = 5'd6;
    localparam ev_code_t EV_CCW    = 5'd7;

    // ev = {ccw, cw, center, right, left, down, up}; lowest index wins.
    function automatic ev_code_t pick_event(input logic [N_EV-1:0] ev);
        ev_code_t code;
        code = EV_NONE;
        if      (ev[0]) code = EV_UP;
        else if (ev[1]) code = EV_DOWN;
        else if (ev[2]) code = EV_LEFT;
        else if (ev[3]) code = EV_RIGHT;
        else if (ev[4]) code = EV_CENTER;
        else if (ev[5]) code = EV_CW;
        else if (ev[6]) code = EV_CCW;
        return code;
    endfunction

endpackage

// File: rtl/input_event_unit_debounce_filter.sv
// 2-FF synchronizer followed by a saturating-counter filter: the stable
// level only flips after the input has disagreed with it for CYCLES cycles.
module debounce_filter #(
    parameter int CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // The cycle that completes the count is itself a differing cycle.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/input_event_unit.sv
// Button/rotary front end for the BTN instruction: debounced presses and
// quadrature detents become single event codes held until acknowledged.
module input_event_unit
    import input_event_unit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int ROT_FILTER_CYCLES = 1000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       BTN_NORTH,
    input  logic       BTN_SOUTH,
    input  logic       BTN_EAST,
    input  logic       BTN_WEST,
    input  logic       ROT_CENTER,
    input  logic       ROT_A,
    input  logic       ROT_B,
    input  logic       iAck,
    output logic [4:0] oBTN,
    output logic       oValid,
    output logic [4:0] oHeld,
    output logic       oOverrun
);

    logic [4:0]      btn_raw;
    logic [4:0]      held;
    logic            rot_a;
    logic            rot_b;
    logic            q1;
    logic            q2;
    logic            q1_p1;
    logic            q2_p1;
    logic [4:0]      btn_rise;
    logic            q1_rise;
    logic [N_EV-1:0] ev;
    ev_code_t        ev_code;
    logic            ev_offer;

    assign btn_raw = {ROT_CENTER, BTN_EAST, BTN_WEST, BTN_SOUTH, BTN_NORTH};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .Clock (Clock),
            .Reset (Reset),
            .raw   (btn_raw[i]),
            .level (held[i])
        );
    end

    debounce_filter #(.CYCLES(ROT_FILTER_CYCLES)) u_rot_a (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (ROT_A),
        .level (rot_a)
    );

    debounce_filter #(.CYCLES(ROT_FILTER_CYCLES)) u_rot_b (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (ROT_B),
        .level (rot_b)
    );

    // oHeld doubles as the previous debounced level for press detection.
    always_comb begin
        btn_rise = held & ~oHeld;
        q1_rise  = q1 & ~q1_p1;
        ev       = {q1_rise & q2_p1, q1_rise & ~q2_p1, btn_rise};
        ev_code  = pick_event(ev);
        ev_offer = |ev;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q1       <= 1'b0;
            q2       <= 1'b0;
            q1_p1    <= 1'b0;
            q2_p1    <= 1'b0;
            oHeld    <= '0;
            oBTN     <= EV_NONE;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            // q1/q2 only move on the diagonal states, so bounce on one contact holds them.
            if (rot_a & rot_b)        q1 <= 1'b1;
            else if (!rot_a & !rot_b) q1 <= 1'b0;
            if (!rot_a & rot_b)       q2 <= 1'b1;
            else if (rot_a & !rot_b)  q2 <= 1'b0;
            q1_p1 <= q1;
            q2_p1 <= q2;
            oHeld <= held;

            if (ev_offer) begin
                if (!oValid || iAck) begin
                    oBTN   <= ev_code;
                    oValid <= 1'b1;
                end else begin
                    oOverrun <= 1'b1;
                end
            end else if (iAck && oValid) begin
                oBTN   <= EV_NONE;
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_event_unit.sv
// Directed and randomized checks of input_event_unit against a timing/code
// model: a stable press yields its code D+3 cycles after the final edge.
module tb_input_event_unit;

    localparam int D = 4;
    localparam int R = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] btn   = '0;
    logic       rot_a = 1'b0;
    logic       rot_b = 1'b0;
    logic       iAck  = 1'b0;
    logic [4:0] oBTN;
    logic       oValid;
    logic [4:0] oHeld;
    logic       oOverrun;

    int vectors     = 0;
    int miscompares = 0;

    // Expected event codes: buttons up/down/left/right/center, then CW, CCW.
    logic [4:0] code_tbl [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};

    input_event_unit #(
        .DEBOUNCE_CYCLES   (D),
        .ROT_FILTER_CYCLES (R)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .BTN_NORTH  (btn[0]),
        .BTN_SOUTH  (btn[1]),
        .BTN_WEST   (btn[2]),
        .BTN_EAST   (btn[3]),
        .ROT_CENTER (btn[4]),
        .ROT_A      (rot_a),
        .ROT_B      (rot_b),
        .iAck       (iAck),
        .oBTN       (oBTN),
        .oValid     (oValid),
        .oHeld      (oHeld),
        .oOverrun   (oOverrun)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_btn"}, 32'(oBTN), 0);
        chk({tag, "_valid"}, 32'(oValid), 0);
        chk({tag, "_held"}, 32'(oHeld), 0);
        chk({tag, "_overrun"}, 32'(oOverrun), 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        check_all_zero("reset");
        Reset = 1'b0;
    endtask

    task automatic ack(input string tag);
        iAck = 1'b1;
        tick(1);
        iAck = 1'b0;
        chk({tag, "_ack_valid"}, 32'(oValid), 0);
        chk({tag, "_ack_btn"}, 32'(oBTN), 0);
    endtask

    // Optional short bounces (each narrower than D), then a stable press.
    task automatic press(input int idx, input int bounces, input string tag);
        int w;
        for (int b = 0; b < bounces; b++) begin
            w = $urandom_range(1, 2);
            btn[idx] = 1'b1;
            tick(w);
            btn[idx] = 1'b0;
            tick(w);
        end
        btn[idx] = 1'b1;
        tick(D + 2);
        chk({tag, "_early_valid"}, 32'(oValid), 0);
        tick(1);
        chk({tag, "_valid"}, 32'(oValid), 1);
        chk({tag, "_code"}, 32'(oBTN), 32'(code_tbl[idx]));
    endtask

    task automatic release_btn(input int idx, input string tag);
        btn[idx] = 1'b0;
        tick(D + 4);
        chk({tag, "_rel_valid"}, 32'(oValid), 0);
        chk({tag, "_rel_held"}, 32'(oHeld), 0);
    endtask

    // Four-step detent ending at 00; s2 = 11 is the step that raises q1.
    task automatic rot_seq(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3,
                           input int kind, input bit chatter, input string tag);
        {rot_a, rot_b} = s1;
        tick(R + 4);
        if (chatter) begin
            rot_a = 1'b0;
            tick(R + 3);
            rot_a = 1'b1;
            tick(R + 3);
            rot_a = 1'b0;
            tick(1);
            rot_a = 1'b1;
            tick(R + 4);
        end
        {rot_a, rot_b} = s2;
        tick(R + 3);
        chk({tag, "_early_valid"}, 32'(oValid), 0);
        tick(1);
        chk({tag, "_valid"}, 32'(oValid), 1);
        chk({tag, "_code"}, 32'(oBTN), 32'(code_tbl[kind]));
        tick(R + 2);
        {rot_a, rot_b} = s3;
        tick(R + 4);
        {rot_a, rot_b} = 2'b00;
        tick(R + 4);
        chk({tag, "_hold_code"}, 32'(oBTN), 32'(code_tbl[kind]));
        chk({tag, "_no_extra"}, 32'(oOverrun), 0);
        ack(tag);
    endtask

    initial begin
        int kind;
        int nb;

        // Reset state
        Reset = 1'b1;
        tick(3);
        check_all_zero("init");
        Reset = 1'b0;
        tick(2);

        // Bounce rejection on BTN_NORTH
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            tick(2);
        end
        chk("bounce_no_event", 32'(oValid), 0);
        chk("bounce_held", 32'(oHeld), 0);
        btn[0] = 1'b1;
        tick(D + 2);
        chk("bounce_early_valid", 32'(oValid), 0);
        chk("bounce_early_held", 32'(oHeld), 0);
        tick(1);
        chk("bounce_valid", 32'(oValid), 1);
        chk("bounce_code", 32'(oBTN), 1);
        chk("bounce_held_up", 32'(oHeld), 1);
        ack("bounce");
        release_btn(0, "bounce");

        // Overrun: slot full with down, left dropped
        press(1, 0, "ovr_south");
        btn[2] = 1'b1;
        tick(D + 3);
        chk("ovr_code_kept", 32'(oBTN), 2);
        chk("ovr_valid", 32'(oValid), 1);
        chk("ovr_flag", 32'(oOverrun), 1);
        chk("ovr_held", 32'(oHeld), 32'h06);
        ack("ovr");
        chk("ovr_sticky", 32'(oOverrun), 1);
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        tick(D + 4);
        do_reset();

        // Ack/load collision
        press(2, 0, "col_west");
        btn[4] = 1'b1;
        tick(D + 2);
        iAck = 1'b1;
        tick(1);
        iAck = 1'b0;
        chk("col_code", 32'(oBTN), 5);
        chk("col_valid", 32'(oValid), 1);
        chk("col_overrun", 32'(oOverrun), 0);
        ack("col");
        btn[2] = 1'b0;
        btn[4] = 1'b0;
        tick(D + 4);

        // Rotary
        rot_seq(2'b10, 2'b11, 2'b01, 5, 1'b0, "rot_cw");
        rot_seq(2'b01, 2'b11, 2'b10, 6, 1'b0, "rot_ccw");
        rot_seq(2'b10, 2'b11, 2'b01, 5, 1'b1, "rot_chatter");

        // Priority: right and up qualify together
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        tick(D + 3);
        chk("prio_code", 32'(oBTN), 1);
        chk("prio_valid", 32'(oValid), 1);
        tick(3);
        chk("prio_overrun", 32'(oOverrun), 0);
        chk("prio_held", 32'(oHeld), 32'h09);
        ack("prio");
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        tick(D + 4);

        // Reset mid-debounce with BTN_SOUTH held
        btn[1] = 1'b1;
        tick(3);
        Reset = 1'b1;
        tick(2);
        check_all_zero("midrst");
        Reset = 1'b0;
        tick(D + 2);
        chk("midrst_early_valid", 32'(oValid), 0);
        tick(1);
        chk("midrst_valid", 32'(oValid), 1);
        chk("midrst_code", 32'(oBTN), 2);
        ack("midrst");
        release_btn(1, "midrst");

        // Randomized single actions
        for (int k = 0; k < 12; k++) begin
            kind = $urandom_range(0, 6);
            if (kind < 5) begin
                nb = $urandom_range(0, 3);
                press(kind, nb, "rnd_btn");
                ack("rnd_btn");
                release_btn(kind, "rnd_btn");
            end else if (kind == 5) begin
                rot_seq(2'b10, 2'b11, 2'b01, 5, 1'($urandom_range(0, 1)), "rnd_cw");
            end else begin
                rot_seq(2'b01, 2'b11, 2'b10, 6, 1'b0, "rnd_ccw");
            end
        end
        chk("rnd_overrun", 32'(oOverrun), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_event_unit.md
# input_event_unit

Upstream front end for the MiniAlu `BTN` instruction. It synchronizes and debounces the four push buttons and the rotary push (ROT_CENTER), and decodes the rotary quadrature pair (ROT_A/ROT_B). Each press or detent becomes one encoded event, held in a single-entry slot until the ALU acknowledges it. This keeps the combinational `BTN` read stable and guarantees exactly one event per physical action.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles a push button must hold before its debounced level changes (10 ms at 50 MHz).
- ROT_FILTER_CYCLES, 1000, same rule applied to ROT_A and ROT_B before quadrature decode.
- Clock  in  1  system clock (50 MHz); the only clock.
- Reset  in  1  synchronous, active-high reset.
- BTN_NORTH, BTN_SOUTH, BTN_EAST, BTN_WEST, ROT_CENTER  in  1 each  raw asynchronous buttons, 1 = pressed.
- ROT_A, ROT_B  in  1 each  raw asynchronous quadrature contacts.
- iAck  in  1  one-cycle pulse from the ALU when a `BTN` instruction consumes the event.
- oBTN  out  5  event code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 center, 6 clockwise, 7 counter-clockwise; 8–31 never driven.
- oValid  out  1  slot holds an unconsumed event.
- oHeld  out  5  debounced levels {center, right, left, down, up}.
- oOverrun  out  1  sticky; set when an event is dropped because the slot was full.

## Operation
- Every raw input passes through a 2-FF synchronizer. Nothing downstream samples a raw pin.
- Filter, per input: keeps a stable level and a counter.
  - Counter clears whenever the synchronized input equals the stable level.
  - When the input has differed for the full cycle count, the stable level toggles and the counter clears.
  - Counter width is ceil(log2(count+1)) and it saturates; it never wraps.
- Button event: fires on a 0→1 transition of a debounced button level. Release produces no event.
- Quadrature decode, on filtered A/B:
  - q1 sets on A=1,B=1 and clears on A=0,B=0; otherwise it holds.
  - q2 sets on A=0,B=1 and clears on A=1,B=0; otherwise it holds.
  - On a rising edge of q1, sample the previous-cycle q2: q2=0 gives clockwise (6), q2=1 gives counter-clockwise (7).
  - One event per detent. Contact bounce is absorbed by the q1 hysteresis.
- Simultaneous events in one cycle: priority is up > down > left > right > center > CW > CCW. Only the winner is offered to the slot. Losers are dropped silently and do not set oOverrun.
- Slot behaviour:
  - Empty and an event is offered: load oBTN and set oValid.
  - Full, no iAck, and an event is offered: discard the event, set oOverrun, keep oBTN unchanged.
  - iAck while full, no event offered: oValid←0 and oBTN←0 next cycle.
  - iAck and an event offered in the same cycle: the new event loads. oValid stays 1 and oOverrun is unaffected.
  - iAck while empty: ignored.
- oOverrun clears only on Reset.

## Timing
- On Reset, all of the following clear: synchronizers, filter counters, stable levels (0), q1/q2 (0), oBTN=0, oValid=0, oHeld=0, oOverrun=0.
  - A button held through reset, or asserted mid-debounce when reset hits, must re-qualify for the full DEBOUNCE_CYCLES after reset falls. It then produces one event.
- Press latency: a raw edge at cycle 0 that stays stable gives 2 synchronizer cycles, then the debounced level toggles after DEBOUNCE_CYCLES more, then oValid=1 on the next edge. Total: oValid visible at cycle DEBOUNCE_CYCLES+3.
- Rotary latency: the same formula with ROT_FILTER_CYCLES, measured from the A/B transition that completes the q1 rise. Add +1 cycle for the q1 edge register.
- oHeld follows the debounced levels with 1 cycle of register delay.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Event code constants go in the shared definitions header, next to the opcodes: `EV_NONE`, `EV_UP`, `EV_DOWN`, `EV_LEFT`, `EV_RIGHT`, `EV_CENTER`, `EV_CW`, `EV_CCW`.
- One sub-module: `debounce_filter`. It has a parameterized cycle count and contains a 2-FF synchronizer, a saturating counter and the stable level. It is instantiated 7 times.
- Quadrature decode, priority encoder and slot logic live in the top module.
- The `BTN` instance in MiniAlu is replaced by this block. iAck is driven by `wOperation == BTN`, and oBTN feeds `rResult`.

## Test plan
- Bench uses DEBOUNCE_CYCLES=4 and ROT_FILTER_CYCLES=2.
- Bounce rejection: toggle BTN_NORTH every 2 cycles for 20 cycles, then hold it at 1 → exactly one event, oBTN=1 and oValid=1 at 7 cycles after the final edge. Release produces no event. oHeld[0] follows the debounced level.
- Overrun: press BTN_SOUTH, no iAck, then press BTN_WEST → oBTN stays 2 and oOverrun=1. Then pulse iAck → oValid=0, oBTN=0.
- Ack/load collision: with the slot full (code 3), iAck coincides with the BTN_CENTER event cycle → next cycle oBTN=5, oValid=1, oOverrun=0.
- Rotary sequences:
  - A/B stepping 00→10→11→01→00 → one event, oBTN=6 (clockwise).
  - 00→01→11→10→00 → oBTN=7 (counter-clockwise).
  - Chatter on A at the 10 state → still exactly one event.
- Priority and reset:
  - BTN_EAST and BTN_NORTH qualify in the same cycle → oBTN=1, no overrun.
  - Assert Reset mid-debounce with a button held → all outputs 0. After Reset falls, the event appears at DEBOUNCE_CYCLES+3.
